// File: rtl/mm_const_gen_if.sv
// Bus between mm_const_gen and the controller that requests Montgomery constants.
// The controller (master) drives start/p_in; the generator (slave) returns the
// status flags and the derived constants consumed by normal_mm.
interface mm_const_gen_if #(
    parameter int WIDTH = 14
);
    logic             start;
    logic [WIDTH-1:0] p_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] p_out;
    logic [WIDTH-1:0] mu;
    logic [WIDTH-1:0] p_neg;
    logic [WIDTH-1:0] r_mod_p;
    logic [WIDTH-1:0] r2_mod_p;

    modport master (
        output start, p_in,
        input  busy, done, err, p_out, mu, p_neg, r_mod_p, r2_mod_p
    );

    modport slave (
        input  start, p_in,
        output busy, done, err, p_out, mu, p_neg, r_mod_p, r2_mod_p
    );
endinterface

// File: rtl/mm_const_gen.sv
// Montgomery constant generator for normal_mm, R = 2^WIDTH.
// IDLE -> INV (Hensel lifting of p^-1 mod R, WIDTH-1 steps)
//      -> RED (2*WIDTH modular doublings giving R mod p and R^2 mod p)
//      -> FIN (one-cycle done, all result registers updated together) -> IDLE.
// Result registers only change on FIN entry, so a consumer can keep using the
// previous constants while a new modulus is being processed.
module mm_const_gen #(
    parameter int WIDTH = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    mm_const_gen_if.slave bus
);
    // Step counter covers 0 .. 2*WIDTH-1 (RED is the longest phase).
    localparam int CW = $clog2(2 * WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INV,
        S_RED,
        S_FIN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] p_q;      // modulus latched at start
    logic [WIDTH-1:0] inv_q;    // running p^-1 mod 2^(i+1)
    logic [WIDTH:0]   r_q;      // running 2^k mod p, one spare bit for the doubling
    logic [WIDTH-1:0] r1_q;     // R mod p captured mid-way through RED
    logic [CW-1:0]    cnt_q;    // i in INV, k in RED

    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] p_out_q;
    logic [WIDTH-1:0] mu_q;
    logic [WIDTH-1:0] p_neg_q;
    logic [WIDTH-1:0] r_mod_p_q;
    logic [WIDTH-1:0] r2_mod_p_q;

    logic [WIDTH-1:0] bit_d;    // one-hot mask of bit i
    logic [WIDTH-1:0] prod_d;   // p * inv mod R
    logic [WIDTH:0]   r_dbl_d;  // 2r, may reach 2p-2 so needs WIDTH+1 bits
    logic [WIDTH:0]   r_d;      // 2r mod p
    logic             p_bad_d;  // modulus rejected (even, or below 3)

    // Datapath for one Hensel step and one modular doubling step.
    always_comb begin
        // NOTE: every always_comb output gets an unconditional assignment, so no latch can form.
        bit_d   = WIDTH'(1) << cnt_q;
        prod_d  = p_q * inv_q;
        r_dbl_d = r_q << 1;
        r_d     = (r_dbl_d >= {1'b0, p_q}) ? (r_dbl_d - {1'b0, p_q}) : r_dbl_d;
        p_bad_d = !bus.p_in[0] || (bus.p_in < WIDTH'(3));
    end

    // Sequencer: state, iteration registers and registered outputs in one block.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: there is no memory here, so every register is cleared by the async reset;
        // a reset mid-run simply drops the partial inverse/remainder and zeroes the outputs.
        if (!rst_n) begin
            state_q    <= S_IDLE;
            p_q        <= '0;
            inv_q      <= '0;
            r_q        <= '0;
            r1_q       <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            p_out_q    <= '0;
            mu_q       <= '0;
            p_neg_q    <= '0;
            r_mod_p_q  <= '0;
            r2_mod_p_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        p_q   <= bus.p_in;
                        err_q <= 1'b0;
                        if (p_bad_d) begin
                            // Rejected modulus: report immediately with zeroed results.
                            state_q    <= S_FIN;
                            err_q      <= 1'b1;
                            done_q     <= 1'b1;
                            p_out_q    <= '0;
                            mu_q       <= '0;
                            p_neg_q    <= '0;
                            r_mod_p_q  <= '0;
                            r2_mod_p_q <= '0;
                        end else begin
                            state_q <= S_INV;
                            busy_q  <= 1'b1;
                            inv_q   <= WIDTH'(1);
                            cnt_q   <= CW'(1);
                        end
                    end
                end

                S_INV: begin
                    // Fix bit i of p*inv: adding 2^i flips it because p is odd.
                    if ((prod_d & bit_d) != '0) begin
                        inv_q <= inv_q | bit_d;
                    end
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= S_RED;
                        r_q     <= (WIDTH + 1)'(1);
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_RED: begin
                    r_q <= r_d;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        r1_q <= r_d[WIDTH-1:0];
                    end
                    if (cnt_q == CW'(2 * WIDTH - 1)) begin
                        // Final doubling lands directly in the output register.
                        state_q    <= S_FIN;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        p_out_q    <= p_q;
                        mu_q       <= '0 - inv_q;
                        p_neg_q    <= '0 - p_q;
                        r_mod_p_q  <= r1_q;
                        r2_mod_p_q <= r_d[WIDTH-1:0];
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                default: begin
                    // S_FIN: one cycle to let done drop; start is not looked at here.
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.p_out    = p_out_q;
    assign bus.mu       = mu_q;
    assign bus.p_neg    = p_neg_q;
    assign bus.r_mod_p  = r_mod_p_q;
    assign bus.r2_mod_p = r2_mod_p_q;
endmodule
